mkio_channel_select: RTL and testbench
======================================

# mkio_channel_select

Line-side front end feeding the MKIO receiver's DI1/DI0 inputs. It replaces plain A|B OR-ing with:
- 2-flop synchronisation of all four line inputs.
- Per-line glitch filtering.
- Activity-based locking onto one channel, A or B.

It forwards only the locked channel's clean Manchester levels and flags line errors and cross-channel conflicts to the terminal controller. It runs on the 32 MHz system clock: 32 cycles per 1 µs MKIO bit.

## Interface
- FILT_LEN, 3, consecutive identical synchronised samples required before a filtered line changes level (legal range 2..15)
- IDLE_CYCLES, 64, cycles without activity on the locked channel before the lock is released (legal range 2..1023)
- clk  in  1  system clock (32 MHz)
- reset  in  1  asynchronous, active-high reset
- DI1A, DI0A  in  1 each  channel A differential line inputs (asynchronous)
- DI1B, DI0B  in  1 each  channel B line inputs (asynchronous)
- DI1, DI0  out  1 each  registered, forwarded levels of the locked channel, to the receiver
- sel_b  out  1  0 = channel A locked or idle, 1 = channel B locked
- locked  out  1  high while in LOCK_A or LOCK_B
- line_error  out  1  one-cycle pulse: both filtered lines of the locked channel are high
- conflict  out  1  one-cycle pulse: first activity on the non-locked channel during a lock episode

## Operation
- Synchroniser: 2 flops per input line. Outputs s1X/s0X, reset value 0.
- Glitch filter, per line:
  - Holds filtered level f and a counter.
  - Counter clears whenever the synchronised value equals f.
  - Counter increments while the synchronised value differs from f.
  - When the counter equals FILT_LEN-1 and the value still differs, f takes the new value and the counter clears.
  - Pulses shorter than FILT_LEN cycles never reach f.
- Activity: actA = f1A | f0A; actB = f1B | f0B.
- FSM states: IDLE, LOCK_A, LOCK_B. Reset state is IDLE.
  - IDLE: actA -> LOCK_A. Otherwise actB -> LOCK_B. Simultaneous activity: A wins.
  - LOCK_X: the idle counter clears on any cycle with actX and increments otherwise. When it reaches IDLE_CYCLES-1 the FSM returns to IDLE and the counter clears.
  - No switching from LOCK_A to LOCK_B or back; a lock always passes through IDLE.
- Output register:
  - Next state LOCK_X: load DI1/DI0 from f1X/f0X, so the first edge is forwarded on the same edge that enters the lock.
  - Next state IDLE: load 0/0.
  - Both f1X and f0X high on the locked channel: output 0/0 and pulse line_error every such cycle.
- Conflict:
  - A sticky flag sets on the first cycle of other-channel activity while locked; conflict pulses on that cycle only.
  - The flag clears on return to IDLE.
  - Activity on both channels in the cycle the lock is taken also produces a conflict pulse on that edge.
- sel_b and locked are registered copies of the FSM state.

## Timing
- Reset values: DI1 = DI0 = 0, sel_b = 0, locked = 0, line_error = 0, conflict = 0, all filters f = 0, all counters 0, FSM IDLE.
- Latency, pin change to DI1/DI0 change, counting from the first clk edge that samples the new level:
  - With filter: FILT_LEN + 3 cycles (4 cycles of structural pipeline delay plus FILT_LEN - 1 cycles of filter qualification).
  - Without filter: 3 cycles.
- Lock release: IDLE_CYCLES cycles after the last cycle with actX, locked falls. With the default of 64 this is a 2 µs gap, shorter than the MKIO inter-message gap and longer than any in-word level.
- Idle counter width: clog2(IDLE_CYCLES). Filter counter width: 4 bits. Counters never wrap because they clear on the terminal count.
- Reset asserted mid-word: all state returns to reset values immediately. Operation resumes at the first edge after deassertion; an in-progress word is simply re-filtered from the synchroniser.

## Configuration
- MKIO_GLITCH_FILTER_EN defined: per-line glitch filters present as described; FILT_LEN is effective.
- Not defined: f = synchronised value directly; FILT_LEN is ignored; latency is 3 cycles. All other behaviour is unchanged.

## Test plan
- Reset, then idle lines for 200 cycles -> all outputs 0, locked = 0.
- Channel A sync pattern (1.5 µs high on DI1A, then 1.5 µs high on DI0A) -> locked = 1 and sel_b = 0 at FILT_LEN+3 cycles; DI1/DI0 reproduce the pattern with FILT_LEN+3 latency; locked falls 64 cycles after DI0A drops.
- 2-cycle spike on DI1B while idle (filter enabled, FILT_LEN = 3) -> no lock, DI1 stays 0; 3-cycle spike -> LOCK_B.
- A and B both asserted on the same edge -> LOCK_A with one conflict pulse. B active again later in the same episode -> no further pulse. After release, B alone -> LOCK_B.
- During LOCK_A, DI1A and DI0A both held high for 5 cycles -> DI1/DI0 = 0/0 and line_error high for 5 cycles.
- Reset pulsed mid-word on channel B -> outputs 0 and locked = 0 asynchronously; the remaining B activity after deassertion re-locks to B.

Source files
------------

// File: rtl/mkio_channel_select.sv
// MKIO line-side front end: 2-flop sync, optional per-line glitch filter, A/B activity lock.
// Define MKIO_GLITCH_FILTER_EN to build the glitch filters; otherwise filtered level = synchronised level.
module mkio_channel_select #(
  parameter int FILT_LEN    = 3,
  parameter int IDLE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic DI1A,
  input  logic DI0A,
  input  logic DI1B,
  input  logic DI0B,
  output logic DI1,
  output logic DI0,
  output logic sel_b,
  output logic locked,
  output logic line_error,
  output logic conflict
);

  localparam int            IW        = $clog2(IDLE_CYCLES);
  localparam logic [IW-1:0] IDLE_TERM = IW'(IDLE_CYCLES - 1);

  if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
    $error("FILT_LEN must be in 2..15");
  end
  if (IDLE_CYCLES < 2 || IDLE_CYCLES > 1023) begin : g_bad_idle_cycles
    $error("IDLE_CYCLES must be in 2..1023");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  // Line order: [3]=DI1B, [2]=DI0B, [1]=DI1A, [0]=DI0A
  logic [3:0] line_in;
  logic [3:0] sync_p0;
  logic [3:0] sync_p1;
  logic [3:0] filt_p2;

  assign line_in = {DI1B, DI0B, DI1A, DI0A};

  // Stage p0/p1: two-flop synchroniser on every asynchronous line input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= line_in;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: per-line glitch filter
`ifdef MKIO_GLITCH_FILTER_EN
  localparam logic [3:0] FILT_TERM = 4'(FILT_LEN - 1);

  for (genvar i = 0; i < 4; i++) begin : g_filt
    logic       lvl;
    logic [3:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (sync_p1[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == FILT_TERM) begin
        lvl <= sync_p1[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end

    assign filt_p2[i] = lvl;
  end
`else
  assign filt_p2 = sync_p1;
`endif

  logic          act_a;
  logic          act_b;
  logic          act_own;
  logic          act_oth;
  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_cnt_nxt;
  logic          conf_flag;
  logic          conf_flag_nxt;
  logic          conf_pulse;
  logic [1:0]    pick;
  logic [1:0]    di_nxt;
  logic          lerr_nxt;

  assign act_a = filt_p2[1] | filt_p2[0];
  assign act_b = filt_p2[3] | filt_p2[2];

  // Stage p3: lock FSM and forwarding decision, evaluated on the filtered levels
  always_comb begin
    state_nxt    = state;
    idle_cnt_nxt = idle_cnt;
    conf_pulse   = 1'b0;
    act_own      = 1'b0;
    act_oth      = 1'b0;

    unique case (state)
      IDLE: begin
        idle_cnt_nxt = '0;
        if (act_a) begin
          state_nxt  = LOCK_A;
          conf_pulse = act_b;
        end else if (act_b) begin
          state_nxt = LOCK_B;
        end
      end
      LOCK_A, LOCK_B: begin
        act_own    = (state == LOCK_B) ? act_b : act_a;
        act_oth    = (state == LOCK_B) ? act_a : act_b;
        conf_pulse = act_oth & ~conf_flag;
        if (act_own) begin
          idle_cnt_nxt = '0;
        end else if (idle_cnt == IDLE_TERM) begin
          idle_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
      end
      default: begin
        state_nxt    = IDLE;
        idle_cnt_nxt = '0;
      end
    endcase

    conf_flag_nxt = (state_nxt == IDLE) ? 1'b0 : (conf_flag | conf_pulse);

    // Forward from the channel being entered so the first edge is not lost
    pick     = (state_nxt == LOCK_B) ? filt_p2[3:2] : filt_p2[1:0];
    di_nxt   = 2'b00;
    lerr_nxt = 1'b0;
    if (state_nxt != IDLE) begin
      if (&pick) begin
        lerr_nxt = 1'b1;
      end else begin
        di_nxt = pick;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idle_cnt   <= '0;
      conf_flag  <= 1'b0;
      DI1        <= 1'b0;
      DI0        <= 1'b0;
      sel_b      <= 1'b0;
      locked     <= 1'b0;
      line_error <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      state      <= state_nxt;
      idle_cnt   <= idle_cnt_nxt;
      conf_flag  <= conf_flag_nxt;
      {DI1, DI0} <= di_nxt;
      sel_b      <= (state_nxt == LOCK_B);
      locked     <= (state_nxt != IDLE);
      line_error <= lerr_nxt;
      conflict   <= conf_pulse;
    end
  end

endmodule

// File: tb/tb_mkio_channel_select.sv
// Bench for mkio_channel_select: directed line scenarios with literal expectations, then random
// line activity, all compared each cycle against a timestamp-based behavioural model.
module tb_mkio_channel_select;

  localparam int FL = 3;
  localparam int IC = 64;
`ifdef MKIO_GLITCH_FILTER_EN
  localparam int LAT = FL + 3;
`else
  localparam int LAT = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic DI1A  = 1'b0;
  logic DI0A  = 1'b0;
  logic DI1B  = 1'b0;
  logic DI0B  = 1'b0;
  logic DI1, DI0, sel_b, locked, line_error, conflict;

  int n_checks  = 0;
  int n_fail    = 0;
  bit cmp_en    = 1'b0;
  int conf_seen = 0;
  int lerr_seen = 0;

  always #5 clk = ~clk;

  mkio_channel_select #(
    .FILT_LEN   (FL),
    .IDLE_CYCLES(IC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .DI1A      (DI1A),
    .DI0A      (DI0A),
    .DI1B      (DI1B),
    .DI0B      (DI0B),
    .DI1       (DI1),
    .DI0       (DI0),
    .sel_b     (sel_b),
    .locked    (locked),
    .line_error(line_error),
    .conflict  (conflict)
  );

  // Behavioural model: pin history, window-based filter, owner + last-activity timestamp
  logic [3:0] m_p0, m_p1;
`ifdef MKIO_GLITCH_FILTER_EN
  logic [3:0]  m_f;
  logic [15:0] m_hist [4];
`endif
  int   m_owner, m_last, m_edge;
  bit   m_seen;
  logic m_di1, m_di0, m_selb, m_locked, m_lerr, m_conf;

  task automatic model_reset();
    m_p0 = '0;
    m_p1 = '0;
`ifdef MKIO_GLITCH_FILTER_EN
    m_f = '0;
    for (int i = 0; i < 4; i++) m_hist[i] = '0;
`endif
    m_owner  = 0;
    m_last   = 0;
    m_edge   = 0;
    m_seen   = 1'b0;
    m_di1    = 1'b0;
    m_di0    = 1'b0;
    m_selb   = 1'b0;
    m_locked = 1'b0;
    m_lerr   = 1'b0;
    m_conf   = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] f;
    logic       a, b, own, oth;
    logic [1:0] pick;
`ifdef MKIO_GLITCH_FILTER_EN
    bit         all_new;
    f = m_f;
`else
    f = m_p1;
`endif
    a = |f[1:0];
    b = |f[3:2];
    m_edge++;
    m_conf = 1'b0;
    if (m_owner == 0) begin
      if (a) begin
        m_owner = 1;
        m_last  = m_edge;
        m_conf  = b;
        m_seen  = b;
      end else if (b) begin
        m_owner = 2;
        m_last  = m_edge;
      end
    end else begin
      own = (m_owner == 1) ? a : b;
      oth = (m_owner == 1) ? b : a;
      if (oth && !m_seen) begin
        m_conf = 1'b1;
        m_seen = 1'b1;
      end
      if (own) m_last = m_edge;
      else if (m_edge - m_last >= IC) m_owner = 0;
    end
    if (m_owner == 0) m_seen = 1'b0;
    pick     = (m_owner == 2) ? f[3:2] : f[1:0];
    m_locked = (m_owner != 0);
    m_selb   = (m_owner == 2);
    m_lerr   = m_locked && (pick == 2'b11);
    m_di1    = m_locked && !m_lerr && pick[1];
    m_di0    = m_locked && !m_lerr && pick[0];
`ifdef MKIO_GLITCH_FILTER_EN
    for (int i = 0; i < 4; i++) begin
      m_hist[i] = {m_hist[i][14:0], m_p1[i]};
      all_new = 1'b1;
      for (int j = 0; j < FL; j++) if (m_hist[i][j] == m_f[i]) all_new = 1'b0;
      if (all_new) m_f[i] = ~m_f[i];
    end
`endif
    m_p1 = m_p0;
    m_p0 = {DI1B, DI0B, DI1A, DI0A};
  endtask

  initial begin : model
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (cmp_en && !reset) begin
        chk1("DI1", DI1, m_di1);
        chk1("DI0", DI0, m_di0);
        chk1("sel_b", sel_b, m_selb);
        chk1("locked", locked, m_locked);
        chk1("line_error", line_error, m_lerr);
        chk1("conflict", conflict, m_conf);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_count(input int n);
    repeat (n) begin
      @(negedge clk);
      if (conflict) conf_seen++;
      if (line_error) lerr_seen++;
    end
  endtask

  initial begin : stim
    logic [3:0] lines;
    logic [1:0] mode;
    int         len;

    tick(3);
    chk1("rst_DI1", DI1, 1'b0);
    chk1("rst_DI0", DI0, 1'b0);
    chk1("rst_sel_b", sel_b, 1'b0);
    chk1("rst_locked", locked, 1'b0);
    chk1("rst_line_error", line_error, 1'b0);
    chk1("rst_conflict", conflict, 1'b0);
    reset  = 1'b0;
    cmp_en = 1'b1;
    tick(200);
    chk1("idle_locked", locked, 1'b0);

    // Channel A sync pattern: 48 cycles DI1A, 48 cycles DI0A
    DI1A = 1'b1;
    tick(LAT - 1);
    chk1("a_DI1_early", DI1, 1'b0);
    chk1("a_locked_early", locked, 1'b0);
    tick(1);
    chk1("a_DI1_lat", DI1, 1'b1);
    chk1("a_locked_lat", locked, 1'b1);
    chk1("a_sel_b_lat", sel_b, 1'b0);
    tick(48 - LAT);
    DI1A = 1'b0;
    DI0A = 1'b1;
    tick(48);
    DI0A = 1'b0;
    tick(LAT - 1);
    chk1("a_DI0_hold", DI0, 1'b1);
    tick(1);
    chk1("a_DI0_fall", DI0, 1'b0);
    tick(62);
    chk1("a_locked_hold", locked, 1'b1);
    tick(1);
    chk1("a_locked_release", locked, 1'b0);
    tick(20);

`ifdef MKIO_GLITCH_FILTER_EN
    // Short spike rejected, FILT_LEN spike accepted
    DI1B = 1'b1;
    tick(2);
    DI1B = 1'b0;
    tick(20);
    chk1("spike2_locked", locked, 1'b0);
    chk1("spike2_DI1", DI1, 1'b0);
    DI1B = 1'b1;
    tick(3);
    DI1B = 1'b0;
    tick(LAT - 3);
    chk1("spike3_locked", locked, 1'b1);
    chk1("spike3_sel_b", sel_b, 1'b1);
    chk1("spike3_DI1", DI1, 1'b1);
    tick(100);
`endif

    // Simultaneous A and B: A wins, one conflict pulse per episode
    DI1A = 1'b1;
    DI1B = 1'b1;
    tick(LAT);
    chk1("both_locked", locked, 1'b1);
    chk1("both_sel_b", sel_b, 1'b0);
    chk1("both_conflict", conflict, 1'b1);
    tick(1);
    chk1("both_conflict_once", conflict, 1'b0);
    conf_seen = 0;
    run_count(8);
    DI1A = 1'b0;
    DI1B = 1'b0;
    run_count(10);
    DI0B = 1'b1;
    run_count(5);
    DI0B = 1'b0;
    run_count(20);
    chkn("conflict_repeat", conf_seen, 0);
    chk1("episode_locked", locked, 1'b1);
    chk1("episode_sel_b", sel_b, 1'b0);
    tick(80);
    chk1("episode_released", locked, 1'b0);
    DI0B = 1'b1;
    tick(LAT);
    chk1("b_after_locked", locked, 1'b1);
    chk1("b_after_sel_b", sel_b, 1'b1);
    tick(10);
    DI0B = 1'b0;
    tick(100);

    // Both A lines high for 5 cycles during LOCK_A
    DI1A = 1'b1;
    tick(10);
    lerr_seen = 0;
    DI0A = 1'b1;
    run_count(5);
    DI0A = 1'b0;
    run_count(20);
    chkn("line_error_cycles", lerr_seen, 5);
    DI1A = 1'b0;
    tick(100);

    // Reset pulsed mid-word on channel B
    DI1B = 1'b1;
    tick(20);
    chk1("b_word_locked", locked, 1'b1);
    chk1("b_word_sel_b", sel_b, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("midrst_DI1", DI1, 1'b0);
    chk1("midrst_locked", locked, 1'b0);
    chk1("midrst_sel_b", sel_b, 1'b0);
    tick(2);
    reset = 1'b0;
    tick(LAT - 1);
    chk1("relock_early", locked, 1'b0);
    tick(1);
    chk1("relock_locked", locked, 1'b1);
    chk1("relock_sel_b", sel_b, 1'b1);
    chk1("relock_DI1", DI1, 1'b1);
    DI1B = 1'b0;
    tick(100);

    // Random line activity, with idle gaps so locks release
    lines = '0;
    for (int s = 0; s < 24; s++) begin
      mode = 2'($urandom_range(0, 3));
      len  = $urandom_range(50, 250);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        for (int l = 0; l < 4; l++) begin
          if ((l < 2) ? mode[0] : mode[1]) begin
            if ($urandom_range(0, 4) == 0) lines[l] = ~lines[l];
          end else begin
            lines[l] = ($urandom_range(0, 30) == 0);
          end
        end
        {DI1B, DI0B, DI1A, DI0A} = lines;
      end
      lines = '0;
      {DI1B, DI0B, DI1A, DI0A} = lines;
      tick($urandom_range(5, 120));
    end
    tick(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
